sample_serializer: RTL and testbench
====================================

Name: sample_serializer

Overview:
Parametrised parallel-to-serial front end that feeds bit-serial sample streams into the DSP processing blocks. It accepts a frame of CHANNELS signed samples over a valid/ready handshake. The frame is shifted out one bit per clock, channel 0 first, with a frame strobe and a channel index. It adds selectable bit order and an inter-frame gap, and sustains back-to-back frames with no bubble.

Parameters:
WIDTH, 12, bits per sample.
CHANNELS, 1, samples per frame, serialized in order 0..CHANNELS-1.
MSB_FIRST, 1, 1 = sample bit WIDTH-1 first; 0 = bit 0 first.
IDLE_BITS, 0, idle clocks (sdata=0) inserted after the last bit of each frame.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
s_valid  in  1  frame available on s_data.
s_ready  out  1  block can accept a frame this cycle (combinational from state).
s_data  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
sdata  out  1  serial data bit, registered.
sframe  out  1  high during the first bit of channel 0 of each frame, registered.
sword  out  1  high during the first bit of every channel word, registered.
schan  out  max(1,clog2(CHANNELS))  channel index of the current bit, registered.
sbusy  out  1  high while SHIFT or GAP, registered.

Behaviour:
- Reset (rst_n low at posedge): state IDLE; sdata=0, sframe=0, sword=0, schan=0, sbusy=0; bit and channel counters 0; shift register cleared. Reset mid-frame discards the frame with no partial completion.
- States:
  - IDLE: no frame in progress.
  - SHIFT: outputs one bit per clock; bit counter 0..WIDTH-1 and channel counter 0..CHANNELS-1.
  - GAP: only when IDLE_BITS>0; gap counter 0..IDLE_BITS-1.
- Accept: s_valid && s_ready at a posedge. The full s_data vector is captured into the internal shift register at that edge. The first bit appears on sdata in the same edge's register update, so it is visible the cycle after accept (latency 1).
- s_ready is high in exactly three cases:
  - in IDLE;
  - in SHIFT on the last bit of the last channel, when IDLE_BITS==0;
  - in GAP on the last gap cycle.
  It is low otherwise. s_data is ignored when no handshake occurs.
- SHIFT sequencing:
  - Each clock, the next bit of the current channel goes out in the order set by MSB_FIRST.
  - After bit WIDTH-1 of channel c<CHANNELS-1, move to bit 0 of channel c+1.
  - After the last bit of the last channel: with IDLE_BITS>0 go to GAP; otherwise go to SHIFT of the new frame if accepted, else IDLE.
- GAP: sdata=0, sframe=0, sword=0, sbusy=1. On the last gap cycle, go to SHIFT if a frame is accepted, else IDLE.
- sframe and sword are high only on bit 0 of their word. schan holds the index for every bit of the word and reads 0 in IDLE and GAP.
- IDLE outputs: sdata=0, sbusy=0.
- Streaming period is CHANNELS*WIDTH+IDLE_BITS clocks per frame. With IDLE_BITS=0 and s_valid held high, sdata is continuous and sframe pulses every CHANNELS*WIDTH clocks.
- The sample is treated as a raw bit pattern: negative values serialize as two's complement with no sign handling. Widths are exact; no truncation or extension.
- s_valid dropping while not ready has no effect. Protocol requires s_data stable only in the accept cycle.

Test Plan:
1. WIDTH=12, CHANNELS=1, MSB_FIRST=1. Reset, then one frame 50 (0x032) -> sdata over 12 cycles = 000000110010; sframe=sword=1 on the first bit only; sbusy high 12 cycles; then IDLE, s_ready=1.
2. Same config, s_valid held high with 50, -13, -115 -> continuous 000000110010 111111110011 111110001101 with no gap; sframe every 12 clocks; s_ready high only on each 12th bit.
3. MSB_FIRST=0, frame 50 -> sdata = 010011000000.
4. CHANNELS=2, IDLE_BITS=3, frame {ch1=20 (0x014), ch0=115 (0x073)} -> 000001110011 then 000000010100 then 3 zero cycles. schan=0 for 12 cycles then 1 for 12. sword pulses at bits 0 and 12, sframe only at 0. s_ready high on the 3rd gap cycle.
5. Assert rst_n low at bit 5 of frame 200 -> next cycle all outputs 0, state IDLE, s_ready=1. The next frame 46 serializes fully from bit 0 (000000101110).
6. s_valid low during the last bit and asserted 4 cycles later (IDLE_BITS=0) -> outputs 0 with sbusy=0 for the idle cycles; the new frame's first bit appears one cycle after accept.

Source files
------------

// File: rtl/sample_serializer.sv
// Parallel-to-serial front end: accepts a frame of CHANNELS samples over
// valid/ready and shifts it out one bit per clock, channel 0 first, with
// frame/word strobes, a channel index and an optional inter-frame gap.
module sample_serializer #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned CHANNELS  = 1,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned IDLE_BITS = 0,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    output logic                      sdata,
    output logic                      sframe,
    output logic                      sword,
    output logic [CH_W-1:0]           schan,
    output logic                      sbusy
);

    localparam int unsigned FRAME_W = CHANNELS * WIDTH;
    localparam int unsigned BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GAP_W   = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
    localparam int unsigned POS_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CH_W-1:0]    chan_q, chan_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               sdata_q, sdata_d;
    logic               sframe_q, sframe_d;
    logic               sword_q, sword_d;
    logic [CH_W-1:0]    schan_q, schan_d;
    logic               sbusy_q, sbusy_d;

    logic last_bit;
    logic last_chan;
    logic last_gap;
    logic accept;

    // Selects bit b (in transmit order) of channel c from a captured frame.
    function automatic logic pick_bit(input logic [FRAME_W-1:0] frame,
                                      input logic [CH_W-1:0]    c,
                                      input logic [BIT_W-1:0]   b);
        logic [BIT_W-1:0] bi;
        logic [POS_W-1:0] pos;
        bi  = MSB_FIRST ? (BIT_W'(WIDTH - 1) - b) : b;
        pos = POS_W'(c) * POS_W'(WIDTH) + POS_W'(bi);
        return frame[pos];
    endfunction

    assign last_bit  = (bit_q == BIT_W'(WIDTH - 1));
    assign last_chan = (chan_q == CH_W'(CHANNELS - 1));
    assign last_gap  = (gap_q == GAP_W'(IDLE_BITS - 1));

    // Ready whenever the next clock would otherwise leave the frame slot empty.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE:  s_ready = 1'b1;
            ST_SHIFT: s_ready = last_bit && last_chan && (IDLE_BITS == 0);
            ST_GAP:   s_ready = last_gap;
            default:  s_ready = 1'b0;
        endcase
    end

    assign accept = s_valid && s_ready;

    // Next-state and next-output logic; an accept overrides the end-of-frame path.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        chan_d   = chan_q;
        gap_d    = gap_q;
        shreg_d  = shreg_q;
        sdata_d  = 1'b0;
        sframe_d = 1'b0;
        sword_d  = 1'b0;
        schan_d  = '0;
        sbusy_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (!(last_bit && last_chan)) begin
                    if (last_bit) begin
                        bit_d  = '0;
                        chan_d = chan_q + CH_W'(1);
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                    sdata_d = pick_bit(shreg_q, chan_d, bit_d);
                    sword_d = last_bit;
                    schan_d = chan_d;
                    sbusy_d = 1'b1;
                end else if (IDLE_BITS > 0) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    sbusy_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (last_gap) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                    sbusy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d  = ST_SHIFT;
            bit_d    = '0;
            chan_d   = '0;
            shreg_d  = s_data;
            sdata_d  = pick_bit(s_data, '0, '0);
            sframe_d = 1'b1;
            sword_d  = 1'b1;
            schan_d  = '0;
            sbusy_d  = 1'b1;
        end
    end

    // State, counters, frame capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            chan_q   <= '0;
            gap_q    <= '0;
            shreg_q  <= '0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
            sword_q  <= 1'b0;
            schan_q  <= '0;
            sbusy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            chan_q   <= chan_d;
            gap_q    <= gap_d;
            shreg_q  <= shreg_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
            sword_q  <= sword_d;
            schan_q  <= schan_d;
            sbusy_q  <= sbusy_d;
        end
    end

    assign sdata  = sdata_q;
    assign sframe = sframe_q;
    assign sword  = sword_q;
    assign schan  = schan_q;
    assign sbusy  = sbusy_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: three configurations driven in lockstep and
// compared every cycle against a frame/position reference model.
module tb_sample_serializer;

    localparam int W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  vld;
    logic [35:0] dat [3];
    wire  [2:0]  o_rdy, o_d, o_f, o_w, o_b;
    wire  [0:0]  ch_a, ch_b;
    wire  [1:0]  ch_c;

    // A: 1 channel, MSB first, no gap
    sample_serializer #(.WIDTH(12), .CHANNELS(1), .MSB_FIRST(1'b1), .IDLE_BITS(0)) u_a (
        .clk(clk), .rst_n(rst_n), .s_valid(vld[0]), .s_ready(o_rdy[0]),
        .s_data(dat[0][11:0]), .sdata(o_d[0]), .sframe(o_f[0]), .sword(o_w[0]),
        .schan(ch_a), .sbusy(o_b[0]));

    // B: 2 channels, MSB first, 3 gap clocks
    sample_serializer #(.WIDTH(12), .CHANNELS(2), .MSB_FIRST(1'b1), .IDLE_BITS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .s_valid(vld[1]), .s_ready(o_rdy[1]),
        .s_data(dat[1][23:0]), .sdata(o_d[1]), .sframe(o_f[1]), .sword(o_w[1]),
        .schan(ch_b), .sbusy(o_b[1]));

    // C: 3 channels, LSB first, 1 gap clock
    sample_serializer #(.WIDTH(12), .CHANNELS(3), .MSB_FIRST(1'b0), .IDLE_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .s_valid(vld[2]), .s_ready(o_rdy[2]),
        .s_data(dat[2]), .sdata(o_d[2]), .sframe(o_f[2]), .sword(o_w[2]),
        .schan(ch_c), .sbusy(o_b[2]));

    int vectors     = 0;
    int miscompares = 0;

    int ch_cfg  [3] = '{1, 2, 3};
    int gap_cfg [3] = '{0, 3, 1};
    bit msb_cfg [3] = '{1'b1, 1'b1, 1'b0};

    // Reference model: the frame in flight and the clock position within its period.
    logic [35:0] m_frame [3];
    int          m_pos   [3];
    logic [2:0]  acc;

    function automatic int period(input int d);
        return ch_cfg[d] * W + gap_cfg[d];
    endfunction

    function automatic logic m_ready(input int d);
        return (m_pos[d] < 0) || (m_pos[d] == period(d) - 1);
    endfunction

    // Expected {sdata, sframe, sword, schan[1:0], sbusy} for the current clock.
    function automatic logic [5:0] m_tok(input int d);
        int p, c, b, bi;
        if (m_pos[d] < 0) return 6'b000000;
        p = m_pos[d];
        if (p >= ch_cfg[d] * W) return 6'b000001;
        c  = p / W;
        b  = p % W;
        bi = msb_cfg[d] ? (W - 1 - b) : b;
        return {m_frame[d][c * W + bi], (p == 0), (b == 0), 2'(c), 1'b1};
    endfunction

    function automatic logic [1:0] obs_ch(input int d);
        case (d)
            0:       return {1'b0, ch_a};
            1:       return {1'b0, ch_b};
            default: return ch_c;
        endcase
    endfunction

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic step();
        logic [5:0] tok;
        for (int d = 0; d < 3; d++) begin
            chk("s_ready", d, 64'(o_rdy[d]), 64'(m_ready(d)));
            acc[d] = rst_n && vld[d] && m_ready(d);
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_pos[d] = -1;
            end else if (acc[d]) begin
                m_frame[d] = dat[d];
                m_pos[d]   = 0;
            end else if (m_pos[d] >= 0) begin
                m_pos[d]++;
                if (m_pos[d] == period(d)) m_pos[d] = -1;
            end
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            tok = m_tok(d);
            chk("sdata",  d, 64'(o_d[d]),     64'(tok[5]));
            chk("sframe", d, 64'(o_f[d]),     64'(tok[4]));
            chk("sword",  d, 64'(o_w[d]),     64'(tok[3]));
            chk("schan",  d, 64'(obs_ch(d)),  64'(tok[2:1]));
            chk("sbusy",  d, 64'(o_b[d]),     64'(tok[0]));
        end
    endtask

    // Offer one frame (DUT must be ready), then collect n serial bits, first bit in the MSB.
    task automatic send_capture(input int d, input logic [35:0] frame, input int n,
                                output logic [35:0] cap);
        vld[d] = 1'b1;
        dat[d] = frame;
        step();
        chk("accepted", d, 64'(acc[d]), 64'd1);
        vld[d] = 1'b0;
        cap = 36'(o_d[d]);
        for (int i = 1; i < n; i++) begin
            step();
            cap = {cap[34:0], o_d[d]};
        end
    endtask

    logic [35:0] cap;
    logic [35:0] rnd;
    int          got;
    int          ncap;

    initial begin
        rst_n = 1'b0;
        vld   = '0;
        for (int d = 0; d < 3; d++) begin
            dat[d]     = '0;
            m_frame[d] = '0;
            m_pos[d]   = -1;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        step();

        // Single frame, MSB first
        send_capture(0, 36'd50, 12, cap);
        chk("t1_bits", 0, 64'(cap[11:0]), 64'h032);
        repeat (3) step();

        // Back-to-back frames with s_valid held high
        got  = 0;
        ncap = 0;
        cap  = '0;
        vld[0] = 1'b1;
        dat[0] = 36'(12'd50);
        for (int n = 0; n < 60 && ncap < 36; n++) begin
            step();
            if (acc[0]) begin
                got++;
                if (got == 1)      dat[0] = 36'(12'hFF3);
                else if (got == 2) dat[0] = 36'(12'hF8D);
                else               vld[0] = 1'b0;
            end
            if (got > 0) begin
                cap = {cap[34:0], o_d[0]};
                ncap++;
            end
        end
        vld[0] = 1'b0;
        chk("t2_frames", 0, 64'(got), 64'd3);
        chk("t2_bits", 0, 64'(cap), 64'h032FF3F8D);
        repeat (3) step();

        // LSB first
        send_capture(2, 36'd50, 12, cap);
        chk("t3_bits", 2, 64'(cap[11:0]), 64'b010011000000);
        repeat (30) step();

        // Two channels with inter-frame gap
        send_capture(1, 36'({12'd20, 12'd115}), 24, cap);
        chk("t4_bits", 1, 64'(cap[23:0]), 64'h073014);
        repeat (6) step();

        // Reset mid-frame, then a clean frame
        vld[0] = 1'b1;
        dat[0] = 36'd200;
        step();
        vld[0] = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send_capture(0, 36'd46, 12, cap);
        chk("t5_bits", 0, 64'(cap[11:0]), 64'b000000101110);
        step();

        // Valid drops at the last bit, new frame four idle cycles later
        rnd = 36'($urandom());
        send_capture(0, rnd, 12, cap);
        chk("t6_first", 0, 64'(cap[11:0]), 64'(rnd[11:0]));
        repeat (4) step();
        rnd = 36'($urandom());
        send_capture(0, rnd, 12, cap);
        chk("t6_second", 0, 64'(cap[11:0]), 64'(rnd[11:0]));

        // Random traffic on all three configurations
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 3; d++) begin
                vld[d] = ($urandom_range(0, 3) != 0);
                dat[d] = 36'({$urandom(), $urandom()});
            end
            step();
        end
        vld = '0;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
